// File: rtl/aes_pkg.sv
// Shared AES constants, engine FSM state type and GF(2^8) S-box helpers.
// The forward S-box helper is only referenced when SUB_BYTES_FWD_EN is defined.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sbe_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] e;
    r  = 8'h01;
    sq = a;
    e  = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One S-box lane: inverse S-box always; forward S-box and the inv select mux
// only when SUB_BYTES_FWD_EN is defined.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  logic [7:0] inv_byte;

  assign inv_byte = sbox_inv(data_i);

`ifdef SUB_BYTES_FWD_EN
  logic [7:0] fwd_byte;

  assign fwd_byte = sbox_fwd(data_i);

  always_comb begin
    data_o = inv_byte;
    if (!inv_i) data_o = fwd_byte;
  end
`else
  logic unused_inv;

  assign unused_inv = inv_i;
  assign data_o     = inv_byte;
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes engine, LANES bytes per cycle, valid/ready both sides.
// SUB_BYTES_FWD_EN enables forward mode; without it every block gets InvSubBytes.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data
);

  localparam int unsigned BEATS = AES_NBYTES / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sbe_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AES_NBYTES-1:0][AES_BYTE_W-1:0] data_q, data_d;
  logic mode_q;
  logic accept;
  logic last_beat;

  logic [LANES-1:0][3:0]            lane_idx;
  logic [LANES-1:0][AES_BYTE_W-1:0] lane_in;
  logic [LANES-1:0][AES_BYTE_W-1:0] lane_out;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(cnt_q * LANES + l);
    assign lane_in[l]  = data_q[lane_idx[l]];

    sbox_lane u_lane (
      .data_i (lane_in[l]),
      .inv_i  (mode_q),
      .data_o (lane_out[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) data_d[lane_idx[l]] = lane_out[l];
        cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A DONE-state accept overrides the return to IDLE: output and input handshakes share the edge.
    accept = in_valid && in_ready;
    if (accept) begin
      state_d = BUSY;
      cnt_d   = '0;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef SUB_BYTES_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mode_q <= 1'b0;
    else if (accept) mode_q <= in_inv;
  end
`else
  logic unused_in_inv;

  assign unused_in_inv = in_inv;
  assign mode_q        = 1'b1;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench: one engine per legal LANES value, each against a table-based AES model.
`timescale 1ns/1ps
module tb_sub_bytes_engine;

`ifdef SUB_BYTES_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  logic [7:0] sb_t  [256];
  logic [7:0] isb_t [256];

  // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic void build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (pmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      sb_t[x] = s;
    end
    for (int x = 0; x < 256; x++) isb_t[sb_t[x]] = 8'(x);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic eff;
    eff = FWD_EN ? inv : 1'b1;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = eff ? isb_t[d[8*k +: 8]] : sb_t[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_inst
    localparam int unsigned L     = 1 << g;
    localparam int unsigned BEATS = 16 / L;

    logic rst_n, in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [127:0] in_data, out_data;

    sub_bytes_engine #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
    );

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Offer one block, then scramble the inputs and count edges until out_valid.
    task automatic offer(input logic [127:0] d, input logic inv,
                         output logic [127:0] r, output int lat);
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data  = rnd128();
      in_inv   = ~inv;
      lat = 0;
      while (!out_valid && lat < 64) begin
        step();
        lat++;
      end
      r = out_data;
    endtask

    initial begin : run
      logic [127:0] d, a, b, r1, r2;
      logic inv_a, inv_b;
      int lat;
      string t;
      t = $sformatf("L%0d", L);
      rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) step();
      chk({t, "_rst_in_ready"},  128'(in_ready),  128'd1);
      chk({t, "_rst_out_valid"}, 128'(out_valid), 128'd0);
      chk({t, "_rst_out_data"},  out_data,        128'd0);
      rst_n = 1'b1;
      step();

      offer({16{8'h63}}, 1'b1, r1, lat);
      chk({t, "_63_lat"},  128'(lat), 128'(BEATS));
      chk({t, "_63_data"}, r1, model({16{8'h63}}, 1'b1));
      step();

      offer(128'h0, 1'b0, r1, lat);
      chk({t, "_zero_data"}, r1, model(128'h0, 1'b0));
      step();
      offer(128'h53, 1'b0, r1, lat);
      chk({t, "_53_data"}, r1, model(128'h53, 1'b0));
      step();

      for (int n = 0; n < 2; n++) begin
        d = rnd128();
        offer(d, 1'b0, r1, lat);
        chk({t, "_rt_fwd_lat"},  128'(lat), 128'(BEATS));
        chk({t, "_rt_fwd_data"}, r1, model(d, 1'b0));
        step();
        offer(r1, 1'b1, r2, lat);
        chk({t, "_rt_inv_lat"},  128'(lat), 128'(BEATS));
        chk({t, "_rt_inv_data"}, r2, model(r1, 1'b1));
        step();
      end

      a = rnd128(); b = rnd128();
      inv_a = 1'($urandom); inv_b = 1'($urandom);
      out_ready = 1'b0;
      offer(a, inv_a, r1, lat);
      chk({t, "_bp_a_lat"}, 128'(lat), 128'(BEATS));
      in_data = b; in_inv = inv_b; in_valid = 1'b1;
      repeat (5) begin
        step();
        chk({t, "_bp_hold_data"},  out_data,        model(a, inv_a));
        chk({t, "_bp_in_ready"},   128'(in_ready),  128'd0);
        chk({t, "_bp_out_valid"},  128'(out_valid), 128'd1);
      end
      out_ready = 1'b1;
      #1;
      chk({t, "_bp_ready_follows"}, 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0; in_data = rnd128(); in_inv = ~inv_b;
      chk({t, "_bp_b_accepted"}, 128'(out_valid), 128'd0);
      lat = 0;
      while (!out_valid && lat < 64) begin
        step();
        lat++;
      end
      chk({t, "_bp_b_lat"},  128'(lat), 128'(BEATS));
      chk({t, "_bp_b_data"}, out_data, model(b, inv_b));
      step();

      out_ready = 1'b0;
      in_data = rnd128(); in_inv = 1'($urandom); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      chk({t, "_abort_in_ready"},  128'(in_ready),  128'd1);
      chk({t, "_abort_out_valid"}, 128'(out_valid), 128'd0);
      chk({t, "_abort_out_data"},  out_data,        128'd0);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      step();
      d = rnd128(); inv_a = 1'($urandom);
      offer(d, inv_a, r1, lat);
      chk({t, "_fresh_lat"},  128'(lat), 128'(BEATS));
      chk({t, "_fresh_data"}, r1, model(d, inv_a));
      step();
      done_cnt++;
    end
  end

  initial begin
    build_tables();
    for (int i = 0; i < 20000 && done_cnt < 5; i++) @(posedge clk);
    chk("all_instances_done", 128'(done_cnt), 128'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
